psw_stack: RTL and testbench
============================

// Module: psw_stack
// PURPOSE
//  Processor status word register with interrupt priority level and a hardware save stack.
//  Sits beside the ALU/decoder. Holds IE, IPL, N, Z, V and C, evaluates the branch condition,
//  and arbitrates interrupt acceptance. PUSH saves the PSW on interrupt entry; POP (RTI) restores it.
//  Allows nested interrupts without microcode save/restore.
// PARAMETERS
//  WIDTH     16  PSW/data width; layout {IE, IPL, 1..1, N, Z, V, C}
//  IPL_BITS  3   interrupt priority level field width; needs WIDTH >= IPL_BITS+5
//  DEPTH     4   save-stack entries (>=1); count width CW = clog2(DEPTH+1)
// PORTS
//  CLOCK     in   1         all state updates on rising edge
//  RESET_N   in   1         asynchronous, active-low reset
//  D         in   WIDTH     data bus (ALU output) for WE writes
//  WE        in   1         load whole PSW from D at end of cycle
//  ALUWE     in   1         load N,Z,V,C from ALU{N,Z,V,C}
//  ALUN/ALUZ/ALUV/ALUC in 1 ALU result flags
//  IECLR     in   1         clear IE at end of cycle
//  PUSH      in   1         interrupt entry: stack<=PSW, IE<=0, IPL<=NEWIPL
//  NEWIPL    in   IPL_BITS  level of the interrupt being taken
//  POP       in   1         RTI: PSW<=top of stack
//  ERRCLR    in   1         clear OVF/UNF
//  REQLVL    in   IPL_BITS  highest pending request level (0 = none)
//  RE        in   1         gate PSW onto Q
//  IR        in   16        instruction register (branch decode)
//  Q         out  WIDTH     PSW image if RE, else 0; unused bits read 1
//  IE,N,Z,V,C out 1         PSW bits
//  IPL       out  IPL_BITS  current priority level
//  BT        out  1         branch-taken for IR
//  INTACC    out  1         IE & (REQLVL > IPL), combinational
//  CNT       out  CW        stack occupancy
//  FULL,EMPTY out 1         CNT==DEPTH / CNT==0
//  OVF,UNF   out  1         sticky: PUSH when FULL / POP when EMPTY
// BEHAVIOUR
//  - Reset (async, RESET_N=0): IE=0, IPL=0, NZVC=0, CNT=0, OVF=UNF=0. Stack contents are don't-care.
//  - Per-cycle priority, highest first: PUSH&POP both set -> no state change, OVF and UNF both set.
//    Otherwise POP > PUSH > WE > ALUWE for IPL/NZVC.
//  - IE priority: POP/PUSH > IECLR > WE.
//  - PUSH when !FULL: entry[CNT] <= {IE, IPL, NZVC}; CNT+1; IE<=0; IPL<=NEWIPL; NZVC unchanged.
//  - PUSH when FULL: stack, CNT and PSW unchanged; OVF<=1.
//  - POP when !EMPTY: {IE, IPL, NZVC} <= entry[CNT-1]; CNT-1.
//  - POP when EMPTY: PSW unchanged; UNF<=1.
//  - WE: IE<=D[WIDTH-1], IPL<=D[WIDTH-2 -: IPL_BITS], NZVC<=D[3:0]. Takes precedence over ALUWE.
//  - ERRCLR clears OVF/UNF unless a new error occurs in the same cycle (the set wins).
//  - All outputs reflect registered state one cycle after the write; no write bypass to Q.
//  - INTACC uses current (pre-edge) IE and IPL; unsigned compare.
//  - BT: cond set by IR[12:10]. 000 never; 001 Z; 010 N^V; 011 (N^V)|Z; 100 C; 101 C|Z;
//    110 N; 111 V. IR[0]=1 inverts, giving the complementary branch.
// STRUCTURE
//  - Shared package: PSW field-position constants, BT condition encodings, and the reset PSW value.
//  - One sub-module, psw_save_stack: a DEPTH x (IPL_BITS+5) LIFO with push/pop/count/full/empty.
//    Register array; no RAM inference required.
//  - Flag, IPL and branch logic stay in the top module.
// TESTING
//  1. Reset mid-run: NZVC=1111, CNT=2, then RESET_N=0 -> all outputs 0 immediately, EMPTY=1.
//  2. WE D=16'h8000|IPL=5|4'b1010 then ALUWE NZVC=0101 -> IE=1, IPL=5, NZVC=0101; Q=0 when RE=0.
//  3. PUSH NEWIPL=6 from IE=1, IPL=2 -> IE=0, IPL=6, CNT=1; POP -> IE=1, IPL=2, NZVC restored.
//  4. DEPTH=4: five PUSHes -> CNT=4, FULL=1, OVF=1, PSW from 4th push. Five POPs -> UNF=1.
//     ERRCLR -> OVF=UNF=0.
//  5. PUSH&POP same cycle -> no change, OVF=UNF=1. WE&ALUWE same cycle -> NZVC from D.
//  6. BT sweep: all 8 IR[12:10] x IR[0] x 16 NZVC combos vs model. IPL=3 -> INTACC=1 only for
//     REQLVL>=4 with IE=1.

Source files
------------

// File: rtl/psw_stack_pkg.sv
// psw_stack_pkg: PSW field positions, branch condition encodings and reset values
package psw_stack_pkg;
  localparam int C_BIT = 0;
  localparam int V_BIT = 1;
  localparam int Z_BIT = 2;
  localparam int N_BIT = 3;
  localparam logic IE_RST = 1'b0;
  localparam logic [3:0] NZVC_RST = 4'b0000;
  typedef enum logic [2:0] {BC_NEVER, BC_EQ, BC_LT, BC_LE, BC_CS, BC_LS, BC_MI, BC_VS} bt_cond_e;
  function automatic logic bt_eval(bt_cond_e cond, logic [3:0] f);
    logic [7:0] t;
    t = {f[V_BIT], f[N_BIT], f[C_BIT] | f[Z_BIT], f[C_BIT],
         (f[N_BIT] ^ f[V_BIT]) | f[Z_BIT], f[N_BIT] ^ f[V_BIT], f[Z_BIT], 1'b0};
    return t[cond];
  endfunction
endpackage

// File: rtl/psw_stack_if.sv
// psw_stack_if: control, flag and status signals between the decoder/ALU and the PSW block
interface psw_stack_if #(parameter int WIDTH = 16, parameter int IPL_BITS = 3, parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] d, q;
  logic we, aluwe, alun, aluz, aluv, aluc, ieclr, push, pop, errclr, re;
  logic [IPL_BITS-1:0] newipl, reqlvl, ipl;
  logic [15:0] ir;
  logic ie, n, z, v, c, bt, intacc, full, empty, ovf, unf;
  logic [CW-1:0] cnt;
  modport master (
    output d, we, aluwe, alun, aluz, aluv, aluc, ieclr, push, pop, errclr, re, newipl, reqlvl, ir,
    input  q, ie, n, z, v, c, ipl, bt, intacc, cnt, full, empty, ovf, unf
  );
  modport slave (
    input  d, we, aluwe, alun, aluz, aluv, aluc, ieclr, push, pop, errclr, re, newipl, reqlvl, ir,
    output q, ie, n, z, v, c, ipl, bt, intacc, cnt, full, empty, ovf, unf
  );
endinterface

// File: rtl/psw_stack_save_stack.sv
// psw_save_stack: DEPTH-entry register LIFO; caller guarantees no push when full / pop when empty
module psw_save_stack #(
  parameter int EW = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [EW-1:0] i_din,
  output logic [EW-1:0] o_top,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_empty
);
  logic [EW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_push) r_mem[AW'(r_cnt)] <= i_din;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_push) r_cnt <= r_cnt + CW'(1);
    else if (i_pop) r_cnt <= r_cnt - CW'(1);
  assign o_top = r_mem[AW'(r_cnt - CW'(1))];
  assign o_cnt = r_cnt;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/psw_stack.sv
// psw_stack: processor status word with IPL, branch evaluation, interrupt accept and save stack
module psw_stack import psw_stack_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int IPL_BITS = 3,
  parameter int DEPTH = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  psw_stack_if.slave bus
);
  localparam int EW = IPL_BITS + 5;
  localparam int FW = WIDTH - IPL_BITS - 5;
  logic                r_ie, r_ovf, r_unf;
  logic [IPL_BITS-1:0] r_ipl;
  logic [3:0]          r_nzvc;
  logic [EW-1:0]       w_top;
  logic                w_full, w_empty, w_push_ok, w_pop_ok, w_ovf_set, w_unf_set, w_ctl, w_unused;
  assign w_ctl = bus.push | bus.pop;
  assign w_push_ok = bus.push & ~bus.pop & ~w_full;
  assign w_pop_ok = bus.pop & ~bus.push & ~w_empty;
  assign w_ovf_set = bus.push & (bus.pop | w_full);
  assign w_unf_set = bus.pop & (bus.push | w_empty);
  assign w_unused = ^{bus.d, bus.ir};
  psw_save_stack #(.EW(EW), .DEPTH(DEPTH)) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_din   ({r_ie, r_ipl, r_nzvc}),
    .o_top   (w_top),
    .o_cnt   (bus.cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // A stack op, even a rejected one, blocks WE/ALUWE/IECLR for that cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ie <= IE_RST;
      r_ipl <= '0;
      r_nzvc <= NZVC_RST;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.errclr);
      r_unf <= w_unf_set | (r_unf & ~bus.errclr);
      if (w_pop_ok) {r_ie, r_ipl, r_nzvc} <= w_top;
      else if (w_push_ok) begin
        r_ie <= 1'b0;
        r_ipl <= bus.newipl;
      end else if (!w_ctl) begin
        r_ie <= bus.ieclr ? 1'b0 : bus.we ? bus.d[WIDTH-1] : r_ie;
        r_ipl <= bus.we ? bus.d[WIDTH-2 -: IPL_BITS] : r_ipl;
        r_nzvc <= bus.we ? bus.d[3:0] : bus.aluwe ? {bus.alun, bus.aluz, bus.aluv, bus.aluc} : r_nzvc;
      end
    end
  assign bus.q = bus.re ? {r_ie, r_ipl, {FW{1'b1}}, r_nzvc} : '0;
  assign bus.ie = r_ie;
  assign bus.ipl = r_ipl;
  assign {bus.n, bus.z, bus.v, bus.c} = r_nzvc;
  assign bus.bt = bt_eval(bt_cond_e'(bus.ir[12:10]), r_nzvc) ^ bus.ir[0];
  assign bus.intacc = r_ie & (bus.reqlvl > r_ipl);
  assign bus.full = w_full;
  assign bus.empty = w_empty;
  assign bus.ovf = r_ovf;
  assign bus.unf = r_unf;
endmodule

// File: tb/tb_psw_stack.sv
// tb_psw_stack: directed stimulus with a reference model feeding an expected-snapshot scoreboard
module tb_psw_stack;
  typedef struct packed {
    logic [15:0] q;
    logic        ie;
    logic [2:0]  ipl;
    logic [3:0]  nzvc;
    logic        bt, intacc;
    logic [2:0]  cnt;
    logic        full, empty, ovf, unf;
  } snap_t;
  typedef struct {
    string tag;
    snap_t exp;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_tot = 0;
  item_t sb[$];
  logic m_ie, m_ovf, m_unf;
  logic [2:0] m_ipl;
  logic [3:0] m_nzvc;
  logic [7:0] m_stk[$];
  always #5 clk = ~clk;
  psw_stack_if #(.WIDTH(16), .IPL_BITS(3), .DEPTH(4)) bus ();
  psw_stack #(.WIDTH(16), .IPL_BITS(3), .DEPTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  function automatic logic bt_ref(logic [15:0] ir, logic [3:0] f);
    logic r;
    case (ir[12:10])
      3'd0: r = 1'b0;
      3'd1: r = f[2];
      3'd2: r = f[3] ^ f[1];
      3'd3: r = (f[3] ^ f[1]) | f[2];
      3'd4: r = f[0];
      3'd5: r = f[0] | f[2];
      3'd6: r = f[3];
      default: r = f[1];
    endcase
    return r ^ ir[0];
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.q = bus.re ? {m_ie, m_ipl, 8'hFF, m_nzvc} : 16'h0000;
    s.ie = m_ie;
    s.ipl = m_ipl;
    s.nzvc = m_nzvc;
    s.bt = bt_ref(bus.ir, m_nzvc);
    s.intacc = m_ie && (bus.reqlvl > m_ipl);
    s.cnt = 3'(m_stk.size());
    s.full = m_stk.size() == 4;
    s.empty = m_stk.size() == 0;
    s.ovf = m_ovf;
    s.unf = m_unf;
    return s;
  endfunction

  task automatic model_reset();
    m_ie = 1'b0;
    m_ipl = 3'd0;
    m_nzvc = 4'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_update();
    logic so, su;
    logic [7:0] e;
    so = bus.push & (bus.pop | (m_stk.size() == 4));
    su = bus.pop & (bus.push | (m_stk.size() == 0));
    if (bus.pop && !bus.push && m_stk.size() != 0) begin
      e = m_stk.pop_back();
      m_ie = e[7];
      m_ipl = e[6:4];
      m_nzvc = e[3:0];
    end else if (bus.push && !bus.pop && m_stk.size() != 4) begin
      m_stk.push_back({m_ie, m_ipl, m_nzvc});
      m_ie = 1'b0;
      m_ipl = bus.newipl;
    end else if (!bus.push && !bus.pop) begin
      if (bus.we) begin
        m_ipl = bus.d[14:12];
        m_nzvc = bus.d[3:0];
      end else if (bus.aluwe) m_nzvc = {bus.alun, bus.aluz, bus.aluv, bus.aluc};
      if (bus.ieclr) m_ie = 1'b0;
      else if (bus.we) m_ie = bus.d[15];
    end
    m_ovf = so | (m_ovf & ~bus.errclr);
    m_unf = su | (m_unf & ~bus.errclr);
  endtask

  task automatic compare_pop();
    item_t it;
    snap_t o;
    it = sb.pop_front();
    o = {bus.q, bus.ie, bus.ipl, bus.n, bus.z, bus.v, bus.c, bus.bt, bus.intacc,
         bus.cnt, bus.full, bus.empty, bus.ovf, bus.unf};
    n_tot++;
    assert (o === it.exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", it.tag, o, it.exp);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(string tag);
    model_update();
    sb.push_back('{tag, model_snap()});
    @(posedge clk);
    #1;
    compare_pop();
    bus.we = 0; bus.aluwe = 0; bus.ieclr = 0; bus.push = 0; bus.pop = 0; bus.errclr = 0;
  endtask

  task automatic comb(string tag);
    sb.push_back('{tag, model_snap()});
    #1;
    compare_pop();
  endtask

  initial begin
    bus.d = '0; bus.we = 0; bus.aluwe = 0; bus.alun = 0; bus.aluz = 0; bus.aluv = 0; bus.aluc = 0;
    bus.ieclr = 0; bus.push = 0; bus.pop = 0; bus.errclr = 0; bus.re = 0;
    bus.newipl = '0; bus.reqlvl = '0; bus.ir = '0;
    model_reset();
    #12;
    comb("reset");
    rst_n = 1'b1;
    // WE then ALUWE
    bus.d = 16'hD00A; bus.we = 1;
    step("we");
    check("we_ie", 32'(bus.ie), 1);
    check("we_ipl", 32'(bus.ipl), 5);
    check("we_nzvc", 32'({bus.n, bus.z, bus.v, bus.c}), 4'b1010);
    {bus.alun, bus.aluz, bus.aluv, bus.aluc} = 4'b0101; bus.aluwe = 1;
    step("aluwe");
    check("aluwe_nzvc", 32'({bus.n, bus.z, bus.v, bus.c}), 4'b0101);
    check("q_re0", 32'(bus.q), 0);
    bus.re = 1;
    step("re_on");
    check("q_re1", 32'(bus.q), 16'hDFF5);
    // PUSH/POP round trip
    bus.d = 16'hA003; bus.we = 1;
    step("we2");
    bus.newipl = 3'd6; bus.push = 1;
    step("push");
    check("push_ie", 32'(bus.ie), 0);
    check("push_ipl", 32'(bus.ipl), 6);
    check("push_cnt", 32'(bus.cnt), 1);
    bus.pop = 1;
    step("pop");
    check("pop_ie", 32'(bus.ie), 1);
    check("pop_ipl", 32'(bus.ipl), 2);
    check("pop_nzvc", 32'({bus.n, bus.z, bus.v, bus.c}), 4'b0011);
    // overflow / underflow
    for (int i = 1; i <= 5; i++) begin
      bus.newipl = 3'(i); bus.push = 1;
      step("push_n");
    end
    check("full_cnt", 32'(bus.cnt), 4);
    check("full_flag", 32'(bus.full), 1);
    check("ovf", 32'(bus.ovf), 1);
    check("ovf_ipl", 32'(bus.ipl), 4);
    for (int i = 0; i < 5; i++) begin
      bus.pop = 1;
      step("pop_n");
    end
    check("unf", 32'(bus.unf), 1);
    check("unf_empty", 32'(bus.empty), 1);
    check("unf_ipl", 32'(bus.ipl), 2);
    bus.errclr = 1;
    step("errclr");
    check("errclr", 32'({bus.ovf, bus.unf}), 0);
    // simultaneous PUSH&POP, WE&ALUWE
    bus.newipl = 3'd7; bus.push = 1;
    step("push1");
    bus.newipl = 3'd1; bus.push = 1; bus.pop = 1;
    step("pushpop");
    check("pp_cnt", 32'(bus.cnt), 1);
    check("pp_err", 32'({bus.ovf, bus.unf}), 2'b11);
    check("pp_ipl", 32'(bus.ipl), 7);
    bus.errclr = 1;
    step("errclr2");
    bus.d = 16'h800C; bus.we = 1; bus.aluwe = 1;
    {bus.alun, bus.aluz, bus.aluv, bus.aluc} = 4'b0011;
    step("we_aluwe");
    check("we_wins", 32'({bus.n, bus.z, bus.v, bus.c}), 4'hC);
    // asynchronous reset mid-run
    bus.d = 16'h800F; bus.we = 1;
    step("we_f");
    bus.newipl = 3'd2; bus.push = 1;
    step("push2");
    check("pre_rst_cnt", 32'(bus.cnt), 2);
    #3;
    rst_n = 1'b0;
    model_reset();
    comb("mid_reset");
    check("rst_cnt", 32'(bus.cnt), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_nzvc", 32'({bus.n, bus.z, bus.v, bus.c}), 0);
    #1;
    rst_n = 1'b1;
    // branch sweep
    for (int f = 0; f < 16; f++) begin
      bus.d = {1'b1, 3'd3, 8'h00, 4'(f)}; bus.we = 1;
      step("we_sweep");
      for (int cnd = 0; cnd < 8; cnd++)
        for (int inv = 0; inv < 2; inv++) begin
          bus.ir = {3'b000, 3'(cnd), 9'h000, 1'(inv)};
          comb("bt");
        end
    end
    // interrupt acceptance at IPL=3
    for (int r = 0; r < 8; r++) begin
      bus.reqlvl = 3'(r);
      comb("intacc1");
      check("intacc_ie1", 32'(bus.intacc), 32'(r >= 4));
    end
    bus.ieclr = 1;
    step("ieclr");
    for (int r = 0; r < 8; r++) begin
      bus.reqlvl = 3'(r);
      comb("intacc0");
      check("intacc_ie0", 32'(bus.intacc), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
